// File: rtl/adc_sample_scheduler.sv
// Frame-rate scheduler for the MAX10 modular ADC command/response interface.
// Each frame tick walks the enabled channels in ascending order, one command outstanding at a time.
module adc_sample_scheduler #(
    parameter int unsigned SAMPLE_DIV  = 6250,
    parameter int unsigned TIMEOUT_CYC = 1023
) (
    input  logic        clock_clk,
    input  logic        reset_sink_reset_n,
    input  logic        enable,
    input  logic [7:0]  ch_mask,
    output logic        command_valid,
    input  logic        command_ready,
    output logic [4:0]  command_channel,
    output logic        command_startofpacket,
    output logic        command_endofpacket,
    input  logic        response_valid,
    input  logic [4:0]  response_channel,
    input  logic [11:0] response_data,
    output logic        sample_valid,
    output logic [11:0] sample_data,
    output logic [4:0]  sample_channel,
    output logic        frame_done,
    output logic        busy,
    output logic [7:0]  overrun_count,
    output logic [7:0]  timeout_count
);

    localparam logic [15:0] DivLast     = 16'(SAMPLE_DIV - 1);
    localparam logic [15:0] TimeoutLast = 16'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {StIdle, StCmd, StWaitRsp} state_e;

    state_e      r_state, w_state_nxt;
    logic [15:0] r_div_cnt;
    logic [15:0] r_wait_cnt, w_wait_nxt;
    logic [7:0]  r_act_mask, w_act_nxt;
    logic [2:0]  r_sel, w_sel_nxt;
    logic        r_sample_valid, r_frame_done;
    logic [11:0] r_sample_data;
    logic [4:0]  r_sample_channel;
    logic [7:0]  r_overrun_count, r_timeout_count;

    logic        w_tick, w_accept, w_timeout, w_last;
    logic [2:0]  w_first_req, w_lo_act, w_hi_act, w_nxt_act;

    assign w_tick = enable && (r_div_cnt == DivLast);

    always_ff @(posedge clock_clk or negedge reset_sink_reset_n) begin
        if (!reset_sink_reset_n) begin
            r_div_cnt <= '0;
        end else if (!enable || w_tick) begin
            r_div_cnt <= '0;
        end else begin
            r_div_cnt <= r_div_cnt + 16'd1;
        end
    end

    // Priority scans: lowest/highest set bit and the next set bit above the current selection.
    always_comb begin
        w_first_req = '0;
        w_lo_act    = '0;
        w_hi_act    = '0;
        w_nxt_act   = '0;
        for (int i = 7; i >= 0; i--) begin
            if (ch_mask[i])                           w_first_req = 3'(i);
            if (r_act_mask[i])                        w_lo_act    = 3'(i);
            if (r_act_mask[i] && (i > int'(r_sel)))   w_nxt_act   = 3'(i);
        end
        for (int i = 0; i < 8; i++) begin
            if (r_act_mask[i]) w_hi_act = 3'(i);
        end
    end

    assign w_last = (r_sel == w_hi_act);

    always_comb begin
        w_state_nxt = r_state;
        w_act_nxt   = r_act_mask;
        w_sel_nxt   = r_sel;
        w_wait_nxt  = r_wait_cnt;
        w_accept    = 1'b0;
        w_timeout   = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (w_tick && (ch_mask != '0)) begin
                    w_act_nxt   = ch_mask;
                    w_sel_nxt   = w_first_req;
                    w_state_nxt = StCmd;
                end
            end
            StCmd: begin
                if (command_ready) begin
                    w_wait_nxt  = '0;
                    w_state_nxt = StWaitRsp;
                end
            end
            StWaitRsp: begin
                // Expiry wins over a response arriving in the same cycle.
                if (r_wait_cnt == TimeoutLast) begin
                    w_timeout   = 1'b1;
                    w_wait_nxt  = '0;
                    w_state_nxt = StIdle;
                end else if (response_valid) begin
                    w_accept    = 1'b1;
                    w_wait_nxt  = '0;
                    if (w_last) begin
                        w_state_nxt = StIdle;
                    end else begin
                        w_sel_nxt   = w_nxt_act;
                        w_state_nxt = StCmd;
                    end
                end else begin
                    w_wait_nxt = r_wait_cnt + 16'd1;
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge clock_clk or negedge reset_sink_reset_n) begin
        if (!reset_sink_reset_n) begin
            r_state    <= StIdle;
            r_act_mask <= '0;
            r_sel      <= '0;
            r_wait_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_act_mask <= w_act_nxt;
            r_sel      <= w_sel_nxt;
            r_wait_cnt <= w_wait_nxt;
        end
    end

    always_ff @(posedge clock_clk or negedge reset_sink_reset_n) begin
        if (!reset_sink_reset_n) begin
            r_sample_valid   <= 1'b0;
            r_frame_done     <= 1'b0;
            r_sample_data    <= '0;
            r_sample_channel <= '0;
            r_overrun_count  <= '0;
            r_timeout_count  <= '0;
        end else begin
            r_sample_valid <= w_accept;
            r_frame_done   <= w_accept && w_last;
            if (w_accept) begin
                r_sample_data    <= response_data;
                r_sample_channel <= response_channel;
            end
            if (w_timeout && (r_timeout_count != 8'hFF)) begin
                r_timeout_count <= r_timeout_count + 8'd1;
            end
            if (w_tick && (r_state != StIdle) && (r_overrun_count != 8'hFF)) begin
                r_overrun_count <= r_overrun_count + 8'd1;
            end
        end
    end

    assign command_valid         = (r_state == StCmd);
    assign command_channel       = command_valid ? ({2'b00, r_sel} + 5'd1) : 5'd0;
    assign command_startofpacket = command_valid && (r_sel == w_lo_act);
    assign command_endofpacket   = command_valid && w_last;
    assign busy                  = (r_state != StIdle);
    assign sample_valid          = r_sample_valid;
    assign sample_data           = r_sample_data;
    assign sample_channel        = r_sample_channel;
    assign frame_done            = r_frame_done;
    assign overrun_count         = r_overrun_count;
    assign timeout_count         = r_timeout_count;

endmodule

// File: tb/tb_adc_sample_scheduler.sv
// Self-checking bench for adc_sample_scheduler: ADC responder models plus per-scenario tasks.
// Instance a covers frame sequencing/timeouts/reset; instance b covers overrun counting.
module tb_adc_sample_scheduler;

    localparam int DivA = 100;
    localparam int ToA  = 16;
    localparam int DivB = 4;

    typedef struct {
        int   ch;
        int   data;
        int   c;
        logic sop;
        logic eop;
        logic fd;
    } ev_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic        en_a = 1'b0, rdy_a = 1'b1, rv_a = 1'b0;
    logic [7:0]  mask_a = '0;
    logic [4:0]  rch_a = '0;
    logic [11:0] rd_a = '0;
    logic        cv_a, sop_a, eop_a, sv_a, fd_a, busy_a;
    logic [4:0]  cch_a, sch_a;
    logic [11:0] sd_a;
    logic [7:0]  ovr_a, to_a;

    logic        en_b = 1'b0, rv_b = 1'b0;
    logic [7:0]  mask_b = 8'h0B;
    logic [4:0]  rch_b = '0;
    logic [11:0] rd_b = '0;
    logic        cv_b, sop_b, eop_b, sv_b, fd_b, busy_b;
    logic [4:0]  cch_b, sch_b;
    logic [11:0] sd_b;
    logic [7:0]  ovr_b, to_b;

    adc_sample_scheduler #(.SAMPLE_DIV(DivA), .TIMEOUT_CYC(ToA)) u_dut (
        .clock_clk(clk), .reset_sink_reset_n(rst_n), .enable(en_a), .ch_mask(mask_a),
        .command_valid(cv_a), .command_ready(rdy_a), .command_channel(cch_a),
        .command_startofpacket(sop_a), .command_endofpacket(eop_a),
        .response_valid(rv_a), .response_channel(rch_a), .response_data(rd_a),
        .sample_valid(sv_a), .sample_data(sd_a), .sample_channel(sch_a),
        .frame_done(fd_a), .busy(busy_a), .overrun_count(ovr_a), .timeout_count(to_a)
    );

    adc_sample_scheduler #(.SAMPLE_DIV(DivB), .TIMEOUT_CYC(1023)) u_ovr (
        .clock_clk(clk), .reset_sink_reset_n(rst_n), .enable(en_b), .ch_mask(mask_b),
        .command_valid(cv_b), .command_ready(1'b1), .command_channel(cch_b),
        .command_startofpacket(sop_b), .command_endofpacket(eop_b),
        .response_valid(rv_b), .response_channel(rch_b), .response_data(rd_b),
        .sample_valid(sv_b), .sample_data(sd_b), .sample_channel(sch_b),
        .frame_done(fd_b), .busy(busy_b), .overrun_count(ovr_b), .timeout_count(to_b)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rel_cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    ev_t  hs_q[$];
    ev_t  smp_q[$];
    ev_t  rsp_q[$];
    int   fall_q[$];
    logic busy_prev = 1'b0;

    // ADC model for instance a: answers lat_a cycles after each handshake, echoing the channel.
    int         lat_a = 5;
    bit         rsp_on_a = 1'b1;
    int         cnt_a = 0;
    logic [4:0] pend_a = '0;
    always @(negedge clk) begin
        if (!rst_n) begin
            cnt_a = 0;
            rv_a  = 1'b0;
        end else begin
            rv_a = 1'b0;
            if (cnt_a > 0) begin
                cnt_a--;
                if (cnt_a == 0 && rsp_on_a) begin
                    rv_a  = 1'b1;
                    rch_a = pend_a;
                    rd_a  = 12'($urandom) | 12'h001;
                    rsp_q.push_back('{ch: int'(rch_a), data: int'(rd_a), c: cyc,
                                      sop: 1'b0, eop: 1'b0, fd: 1'b0});
                end
            end
            if (cv_a && rdy_a) begin
                cnt_a  = lat_a;
                pend_a = cch_a;
            end
        end
    end

    int         lat_b = 3;
    int         cnt_b = 0;
    logic [4:0] pend_b = '0;
    always @(negedge clk) begin
        if (!rst_n) begin
            cnt_b = 0;
            rv_b  = 1'b0;
        end else begin
            rv_b = 1'b0;
            if (cnt_b > 0) begin
                cnt_b--;
                if (cnt_b == 0) begin
                    rv_b  = 1'b1;
                    rch_b = pend_b;
                    rd_b  = 12'($urandom);
                end
            end
            if (cv_b) begin
                cnt_b  = lat_b;
                pend_b = cch_b;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (cv_a && rdy_a)
                hs_q.push_back('{ch: int'(cch_a), data: 0, c: cyc, sop: sop_a, eop: eop_a, fd: 1'b0});
            if (sv_a)
                smp_q.push_back('{ch: int'(sch_a), data: int'(sd_a), c: cyc,
                                  sop: 1'b0, eop: 1'b0, fd: fd_a});
            if (busy_prev && !busy_a) fall_q.push_back(cyc);
        end
        busy_prev = busy_a;
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        hs_q.delete(); smp_q.delete(); rsp_q.delete(); fall_q.delete();
        @(negedge clk);
        rst_n   = 1'b1;
        rel_cyc = cyc;
    endtask

    task automatic run_to(input int rel);
        while (cyc < rel_cyc + rel) @(negedge clk);
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({cv_a, cch_a, sop_a, eop_a, sv_a, sd_a, sch_a, fd_a, busy_a, ovr_a, to_a} !== '0) begin
            errors++;
            $display("FAIL reset_a outputs got cv=%b ch=%0d busy=%b ovr=%0d to=%0d exp all 0",
                     cv_a, cch_a, busy_a, ovr_a, to_a);
        end
        checks++;
        if ({cv_b, cch_b, sop_b, eop_b, sv_b, sd_b, sch_b, fd_b, busy_b, ovr_b, to_b} !== '0) begin
            errors++;
            $display("FAIL reset_b outputs got cv=%b busy=%b ovr=%0d exp all 0", cv_b, busy_b, ovr_b);
        end
    endtask

    task automatic test_single();
        mask_a = 8'h01; lat_a = 5; rsp_on_a = 1'b1; en_a = 1'b1;
        do_reset();
        run_to(320);
        checks++;
        if (hs_q.size() != 3) begin
            errors++; $display("FAIL single hs_count got %0d exp 3", hs_q.size());
        end
        for (int k = 0; k < 3 && k < hs_q.size(); k++) begin
            checks++;
            if (hs_q[k].ch != 1 || hs_q[k].sop !== 1'b1 || hs_q[k].eop !== 1'b1 ||
                hs_q[k].c != rel_cyc + DivA * (k + 1)) begin
                errors++;
                $display("FAIL single cmd%0d got ch=%0d sop=%b eop=%b cyc=%0d exp ch=1 sop=1 eop=1 cyc=%0d",
                         k, hs_q[k].ch, hs_q[k].sop, hs_q[k].eop, hs_q[k].c, rel_cyc + DivA * (k + 1));
            end
        end
        checks++;
        if (smp_q.size() != 3 || rsp_q.size() != 3) begin
            errors++; $display("FAIL single samples got %0d exp 3", smp_q.size());
        end
        for (int k = 0; k < 3 && k < smp_q.size() && k < rsp_q.size(); k++) begin
            checks++;
            if (smp_q[k].ch != 1 || smp_q[k].data != rsp_q[k].data || smp_q[k].c != rsp_q[k].c + 1 ||
                smp_q[k].fd !== 1'b1) begin
                errors++;
                $display("FAIL single sample%0d got ch=%0d d=%0h cyc=%0d fd=%b exp ch=1 d=%0h cyc=%0d fd=1",
                         k, smp_q[k].ch, smp_q[k].data, smp_q[k].c, smp_q[k].fd,
                         rsp_q[k].data, rsp_q[k].c + 1);
            end
        end
        checks++;
        if (ovr_a !== 8'd0 || to_a !== 8'd0) begin
            errors++; $display("FAIL single counters got ovr=%0d to=%0d exp 0 0", ovr_a, to_a);
        end
    endtask

    // Expected command order is simply the set bits of the latched mask, ascending.
    task automatic test_multi();
        logic [7:0] m;
        int lat, n;
        int exp_ch[$];
        for (int t = 0; t < 4; t++) begin
            m   = (t == 0) ? 8'h85 : 8'($urandom_range(1, 255));
            lat = $urandom_range(1, 8);
            exp_ch.delete();
            for (int i = 0; i < 8; i++) if (m[i]) exp_ch.push_back(i + 1);
            n = exp_ch.size();
            mask_a = m; lat_a = lat; rsp_on_a = 1'b1; en_a = 1'b1;
            do_reset();
            run_to(110);
            mask_a = 8'($urandom);
            run_to(190);
            checks++;
            if (hs_q.size() != n || smp_q.size() != n) begin
                errors++;
                $display("FAIL multi m=%0h counts got hs=%0d smp=%0d exp %0d", m, hs_q.size(),
                         smp_q.size(), n);
            end
            for (int k = 0; k < n && k < hs_q.size(); k++) begin
                checks++;
                if (hs_q[k].ch != exp_ch[k] || hs_q[k].sop !== 1'(k == 0) ||
                    hs_q[k].eop !== 1'(k == n - 1) || hs_q[k].c != rel_cyc + DivA + k * (lat + 1)) begin
                    errors++;
                    $display("FAIL multi m=%0h cmd%0d got ch=%0d sop=%b eop=%b cyc=%0d exp ch=%0d cyc=%0d",
                             m, k, hs_q[k].ch, hs_q[k].sop, hs_q[k].eop, hs_q[k].c, exp_ch[k],
                             rel_cyc + DivA + k * (lat + 1));
                end
            end
            for (int k = 0; k < n && k < smp_q.size() && k < rsp_q.size(); k++) begin
                checks++;
                if (smp_q[k].ch != exp_ch[k] || smp_q[k].data != rsp_q[k].data ||
                    smp_q[k].c != rsp_q[k].c + 1 || smp_q[k].fd !== 1'(k == n - 1)) begin
                    errors++;
                    $display("FAIL multi m=%0h smp%0d got ch=%0d d=%0h cyc=%0d fd=%b exp ch=%0d d=%0h cyc=%0d",
                             m, k, smp_q[k].ch, smp_q[k].data, smp_q[k].c, smp_q[k].fd, exp_ch[k],
                             rsp_q[k].data, rsp_q[k].c + 1);
                end
            end
        end
    endtask

    task automatic test_stall();
        int c0, k;
        mask_a = 8'h04; lat_a = 3; rsp_on_a = 1'b1; en_a = 1'b1;
        do_reset();
        @(posedge clk); #1 rdy_a = 1'b0;
        k = 0;
        while (!cv_a && k < 150) begin @(negedge clk); k++; end
        checks++;
        if (!cv_a) begin
            errors++; $display("FAIL stall no_command got cv=0 exp 1 within 150 cycles");
        end
        c0 = cyc;
        for (int i = 0; i < 7; i++) begin
            if (i > 0) @(negedge clk);
            checks++;
            if (cv_a !== 1'b1 || cch_a !== 5'd3 || sop_a !== 1'b1 || eop_a !== 1'b1) begin
                errors++;
                $display("FAIL stall hold%0d got cv=%b ch=%0d sop=%b eop=%b exp 1 3 1 1",
                         i, cv_a, cch_a, sop_a, eop_a);
            end
        end
        @(posedge clk); #1 rdy_a = 1'b1;
        repeat (20) @(negedge clk);
        checks++;
        if (hs_q.size() != 1 || (hs_q.size() > 0 && hs_q[0].c != c0 + 7) || smp_q.size() != 1) begin
            errors++;
            $display("FAIL stall handshake got n=%0d smp=%0d exp n=1 at cyc %0d smp=1",
                     hs_q.size(), smp_q.size(), c0 + 7);
        end
    endtask

    // Cases: 0 = no response, 1 = response one cycle too late, 2 = last acceptable cycle.
    task automatic test_timeout();
        for (int t = 0; t < 3; t++) begin
            mask_a = 8'h03; en_a = 1'b1;
            rsp_on_a = (t != 0);
            lat_a = (t == 1) ? ToA : ToA - 1;
            do_reset();
            run_to(150);
            if (t == 2) begin
                checks++;
                if (hs_q.size() != 2 || smp_q.size() != 2 || to_a !== 8'd0 || fall_q.size() != 1 ||
                    (hs_q.size() == 2 && fall_q.size() == 1 && fall_q[0] != hs_q[1].c + ToA)) begin
                    errors++;
                    $display("FAIL timeout_edge got hs=%0d smp=%0d to=%0d exp hs=2 smp=2 to=0",
                             hs_q.size(), smp_q.size(), to_a);
                end
            end else begin
                checks++;
                if (hs_q.size() != 1 || smp_q.size() != 0 || to_a !== 8'd1 || fall_q.size() != 1 ||
                    (hs_q.size() == 1 && fall_q.size() == 1 && fall_q[0] != hs_q[0].c + ToA + 1)) begin
                    errors++;
                    $display("FAIL timeout case%0d got hs=%0d smp=%0d to=%0d fall=%0d exp 1 0 1 %0d",
                             t, hs_q.size(), smp_q.size(), to_a,
                             (fall_q.size() > 0) ? fall_q[0] : -1,
                             (hs_q.size() > 0) ? hs_q[0].c + ToA + 1 : -1);
                end
            end
            if (t == 0) begin
                run_to(250);
                checks++;
                if (hs_q.size() != 2 || (hs_q.size() == 2 && (hs_q[1].ch != 1 || hs_q[1].sop !== 1'b1)) ||
                    to_a !== 8'd2) begin
                    errors++;
                    $display("FAIL timeout_refresh got hs=%0d to=%0d exp hs=2 ch1 sop=1 to=2",
                             hs_q.size(), to_a);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        int k;
        mask_a = 8'h01; lat_a = 4; rsp_on_a = 1'b1; en_a = 1'b1;
        do_reset();
        k = 0;
        while (smp_q.size() < 1 && k < 200) begin @(negedge clk); k++; end
        lat_a = 20;
        k = 0;
        while (hs_q.size() < 3 && k < 300) begin @(negedge clk); k++; end
        checks++;
        if (hs_q.size() < 3) begin
            errors++; $display("FAIL rst_setup got %0d commands exp 3", hs_q.size());
        end
        repeat (2) @(negedge clk);
        checks++;
        if (busy_a !== 1'b1 || to_a !== 8'd1 || sd_a === 12'd0) begin
            errors++;
            $display("FAIL rst_pre got busy=%b to=%0d data=%0h exp busy=1 to=1 data!=0", busy_a, to_a, sd_a);
        end
        @(posedge clk); #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({cv_a, cch_a, sop_a, eop_a, sv_a, sd_a, sch_a, fd_a, busy_a, ovr_a, to_a} !== '0) begin
            errors++;
            $display("FAIL rst_async got busy=%b to=%0d data=%0h ch=%0d exp all 0", busy_a, to_a, sd_a, sch_a);
        end
        repeat (2) @(negedge clk);
        hs_q.delete(); smp_q.delete(); rsp_q.delete(); fall_q.delete();
        @(negedge clk);
        rst_n   = 1'b1;
        rel_cyc = cyc;
        k = 0;
        while (hs_q.size() < 1 && k < 150) begin @(negedge clk); k++; end
        // The release cycle counts as cycle 1, so the command lands in cycle SAMPLE_DIV+1.
        checks++;
        if (hs_q.size() < 1 || hs_q[0].c != rel_cyc + DivA) begin
            errors++;
            $display("FAIL rst_restart got n=%0d cyc=%0d exp cyc=%0d", hs_q.size(),
                     (hs_q.size() > 0) ? hs_q[0].c : -1, rel_cyc + DivA);
        end
    endtask

    task automatic test_zero_mask();
        mask_a = 8'h00; en_a = 1'b1; rsp_on_a = 1'b1;
        do_reset();
        run_to(250);
        checks++;
        if (hs_q.size() != 0 || fall_q.size() != 0 || busy_a !== 1'b0 || ovr_a !== 8'd0) begin
            errors++;
            $display("FAIL zero_mask got hs=%0d busy=%b ovr=%0d exp 0 0 0", hs_q.size(), busy_a, ovr_a);
        end
    endtask

    // Frame occupies [tick+1, tick+k*(lat+1)]; any tick inside that window is an overrun.
    task automatic test_overrun();
        int busy_until, m_ovr;
        en_a = 1'b0; en_b = 1'b1; mask_b = 8'h0B;
        do_reset();
        busy_until = -1;
        m_ovr = 0;
        for (int n = 1; n <= 1500; n++) begin
            @(negedge clk);
            if (n % 25 == 0) begin
                checks++;
                if (ovr_b !== 8'(m_ovr)) begin
                    errors++; $display("FAIL overrun n=%0d got %0d exp %0d", n, ovr_b, m_ovr);
                end
            end
            if (n % DivB == DivB - 1) begin
                if (n <= busy_until) m_ovr = (m_ovr < 255) ? m_ovr + 1 : 255;
                else busy_until = n + 3 * (lat_b + 1);
            end
        end
        checks++;
        if (ovr_b !== 8'd255 || m_ovr != 255 || to_b !== 8'd0) begin
            errors++;
            $display("FAIL overrun_sat got ovr=%0d to=%0d exp ovr=255 to=0", ovr_b, to_b);
        end
        en_b = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_multi();
        test_stall();
        test_timeout();
        test_async_reset();
        test_zero_mask();
        test_overrun();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog");
    end

endmodule
